// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Time-shares a two-digit 7-segment display between two requesters. Each
// requester offers a byte through a req/ack handshake; the scheduler picks a
// winner round-robin, captures its byte, and shows it as two hex digits for
// at least DWELL_CYCLES clock cycles before it serves another request.
//
// Optional feature macro: SEG_SCHED_BLANK_LEADING_ZERO_EN
//   When defined, a zero high nibble blanks the left digit instead of
//   showing "0". The right digit is never blanked.
//
// Ports
//   i_Clk     system clock, rising edge
//   i_Rst     asynchronous active-high reset
//   i_Req     per-channel request (bit n = channel n)
//   i_Data0   channel 0 byte (high nibble -> digit 1, low nibble -> digit 2)
//   i_Data1   channel 1 byte (same mapping)
//   o_Ack     one-cycle pulse on the granted channel while its byte is captured
//   o_Busy    high in GRANT and DWELL
//   o_Owner   channel currently shown (valid while o_Valid is high)
//   o_Valid   low until the first grant after reset
//   o_Digit1  left digit, ABCDEFG active-high (bit 6 = A)
//   o_Digit2  right digit, ABCDEFG active-high
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int CNT_W        = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Req,
    input  logic [7:0] i_Data0,
    input  logic [7:0] i_Data1,
    output logic [1:0] o_Ack,
    output logic       o_Busy,
    output logic       o_Owner,
    output logic       o_Valid,
    output logic [6:0] o_Digit1,
    output logic [6:0] o_Digit2
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DWELL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_owner;
    logic             r_grant_ch;
    logic [1:0]       r_ack;
    logic             r_busy;
    logic             r_owner;
    logic             r_valid;
    logic [6:0]       r_digit1;
    logic [6:0]       r_digit2;

    logic             w_req_any;
    logic             w_cnt_last;
    logic             w_winner;
    logic [7:0]       w_sel_data;
    logic [6:0]       w_dig1;
    logic [6:0]       w_dig2;

    // Hex nibble to active-high ABCDEFG segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            4'hF:    seg = 7'h47;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Next-state, arbitration and digit decode.
    always_comb begin
        w_next     = r_state;
        w_req_any  = (i_Req != 2'b00);
        w_cnt_last = (r_cnt == {CNT_W{1'b0}});
        // On a tie the channel that was not shown last wins.
        case (i_Req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_owner;
            default: w_winner = r_last_owner;
        endcase

        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_req_any) w_next = ST_GRANT;
                else           w_next = r_state;
            end
            ST_GRANT: w_next = ST_DWELL;
            ST_DWELL: begin
                if (w_cnt_last) w_next = w_req_any ? ST_GRANT : ST_HOLD;
                else            w_next = ST_DWELL;
            end
            default: w_next = ST_IDLE;
        endcase

        // Data is captured in GRANT whatever i_Req does in that cycle.
        w_sel_data = r_grant_ch ? i_Data1 : i_Data0;
        w_dig2     = hex_to_seg(w_sel_data[3:0]);
`ifdef SEG_SCHED_BLANK_LEADING_ZERO_EN
        if (w_sel_data[7:4] == 4'h0) w_dig1 = 7'h00;
        else                         w_dig1 = hex_to_seg(w_sel_data[7:4]);
`else
        w_dig1 = hex_to_seg(w_sel_data[7:4]);
`endif
    end

    // State register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Ack pulse, busy flag and winner latch; ack rises with entry to GRANT.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_ack      <= 2'b00;
            r_busy     <= 1'b0;
            r_grant_ch <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_GRANT) || (w_next == ST_DWELL);
            if (w_next == ST_GRANT) begin
                r_ack      <= w_winner ? 2'b10 : 2'b01;
                r_grant_ch <= w_winner;
            end else begin
                r_ack      <= 2'b00;
                r_grant_ch <= r_grant_ch;
            end
        end
    end

    // Dwell counter: loads DWELL_CYCLES-1 in GRANT, counts down to 0 in DWELL.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_GRANT) begin
            r_cnt <= CNT_W'(DWELL_CYCLES - 1);
        end else if ((r_state == ST_DWELL) && !w_cnt_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Display registers and round-robin history, updated in GRANT.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_digit1     <= 7'h00;
            r_digit2     <= 7'h00;
            r_owner      <= 1'b0;
            r_valid      <= 1'b0;
            r_last_owner <= 1'b1;
        end else if (r_state == ST_GRANT) begin
            r_digit1     <= w_dig1;
            r_digit2     <= w_dig2;
            r_owner      <= r_grant_ch;
            r_valid      <= 1'b1;
            r_last_owner <= r_grant_ch;
        end else begin
            r_digit1     <= r_digit1;
            r_digit2     <= r_digit2;
            r_owner      <= r_owner;
            r_valid      <= r_valid;
            r_last_owner <= r_last_owner;
        end
    end

    assign o_Ack    = r_ack;
    assign o_Busy   = r_busy;
    assign o_Owner  = r_owner;
    assign o_Valid  = r_valid;
    assign o_Digit1 = r_digit1;
    assign o_Digit2 = r_digit2;

endmodule
